// File: rtl/bus_arbiter_decoder.sv
// Round-robin arbiter for two serial-bus masters with serial slave-ID capture,
// grant timeout/lockout and registered steering outputs for the interconnect mux.
module bus_arbiter_decoder #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       M1_REQ,
  input  logic       M2_REQ,
  input  logic       M1_VALID,
  input  logic       M2_VALID,
  input  logic       M1_TX_ADDR,
  input  logic       M2_TX_ADDR,
  output logic [1:0] bus_grant,
  output logic [1:0] slave_select,
  output logic       M1_GRANT,
  output logic       M2_GRANT,
  output logic       M1_ACK,
  output logic       M2_ACK,
  output logic       M1_ERR,
  output logic       M2_ERR
);

  localparam int unsigned    CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CONNECT, S_RELEASE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_owner, w_owner_nxt;     // 0 = M1, 1 = M2
  logic          r_prio_m2, w_prio_nxt;    // 1 = M2 wins the next contention
  logic          r_lock1, w_lock1_nxt;
  logic          r_lock2, w_lock2_nxt;
  logic          r_bitcnt, w_bitcnt_nxt;
  logic [1:0]    r_id, w_id_nxt;
  logic [CW-1:0] r_tcnt, w_tcnt_nxt;

  logic [1:0]    w_grant_nxt, w_sel_nxt;
  logic          w_ack, w_err, w_rel, w_lockset;
  logic          w_req, w_valid, w_addr;
  logic          w_elig1, w_elig2, w_pick2, w_tmo;

  assign w_req   = r_owner ? M2_REQ     : M1_REQ;
  assign w_valid = r_owner ? M2_VALID   : M1_VALID;
  assign w_addr  = r_owner ? M2_TX_ADDR : M1_TX_ADDR;
  assign w_elig1 = M1_REQ & ~r_lock1;
  assign w_elig2 = M2_REQ & ~r_lock2;
  assign w_pick2 = w_elig2 & (~w_elig1 | r_prio_m2);
  assign w_tmo   = (TIMEOUT != 0) && (r_tcnt == TLAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_prio_m2    <= 1'b0;
      r_lock1      <= 1'b0;
      r_lock2      <= 1'b0;
      r_bitcnt     <= 1'b0;
      r_id         <= '0;
      r_tcnt       <= '0;
      bus_grant    <= '0;
      slave_select <= '0;
      M1_GRANT     <= 1'b0;
      M2_GRANT     <= 1'b0;
      M1_ACK       <= 1'b0;
      M2_ACK       <= 1'b0;
      M1_ERR       <= 1'b0;
      M2_ERR       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_prio_m2    <= w_prio_nxt;
      r_lock1      <= w_lock1_nxt;
      r_lock2      <= w_lock2_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_id         <= w_id_nxt;
      r_tcnt       <= w_tcnt_nxt;
      bus_grant    <= w_grant_nxt;
      slave_select <= w_sel_nxt;
      M1_GRANT     <= (w_grant_nxt == 2'd1);
      M2_GRANT     <= (w_grant_nxt == 2'd2);
      M1_ACK       <= w_ack & ~w_owner_nxt;
      M2_ACK       <= w_ack &  w_owner_nxt;
      M1_ERR       <= w_err & ~w_owner_nxt;
      M2_ERR       <= w_err &  w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_prio_nxt   = r_prio_m2;
    w_bitcnt_nxt = r_bitcnt;
    w_id_nxt     = r_id;
    w_tcnt_nxt   = r_tcnt;
    w_grant_nxt  = bus_grant;
    w_sel_nxt    = slave_select;
    w_ack        = 1'b0;
    w_err        = 1'b0;
    w_rel        = 1'b0;
    w_lockset    = 1'b0;
    // Lockout drops on the first sampled-low REQ, whatever the state.
    w_lock1_nxt  = r_lock1 & M1_REQ;
    w_lock2_nxt  = r_lock2 & M2_REQ;

    case (r_state)
      S_IDLE: begin
        if (w_elig1 || w_elig2) begin
          w_owner_nxt  = w_pick2;
          w_state_nxt  = S_ADDR;
          w_grant_nxt  = w_pick2 ? 2'd2 : 2'd1;
          w_bitcnt_nxt = 1'b0;
          w_id_nxt     = '0;
          w_tcnt_nxt   = '0;
        end
      end
      S_ADDR: begin
        w_tcnt_nxt = r_tcnt + CW'(1);
        if (!w_req) begin
          w_rel = 1'b1;
        end else if (w_tmo) begin
          w_rel     = 1'b1;
          w_err     = 1'b1;
          w_lockset = 1'b1;
        end else if (w_valid) begin
          w_id_nxt = {r_id[0], w_addr};
          if (r_bitcnt) begin
            if ({r_id[0], w_addr} != 2'd0) begin
              w_state_nxt = S_CONNECT;
              w_sel_nxt   = {r_id[0], w_addr};
              w_ack       = 1'b1;
            end else begin
              w_rel = 1'b1;
              w_err = 1'b1;
            end
          end else begin
            w_bitcnt_nxt = 1'b1;
          end
        end
      end
      S_CONNECT: begin
        w_tcnt_nxt = r_tcnt + CW'(1);
        if (!w_req) begin
          w_rel = 1'b1;
        end else if (w_tmo) begin
          w_rel     = 1'b1;
          w_err     = 1'b1;
          w_lockset = 1'b1;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
        w_prio_nxt  = ~r_owner;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_rel) begin
      w_state_nxt = S_RELEASE;
      w_grant_nxt = '0;
      w_sel_nxt   = '0;
    end
    if (w_lockset) begin
      if (r_owner) w_lock2_nxt = 1'b1;
      else         w_lock1_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_decoder.sv
// Directed, table-driven bench for bus_arbiter_decoder (TIMEOUT=8); one vector
// per clock, expected registered outputs checked just after each rising edge.
module tb_bus_arbiter_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       M1_REQ, M2_REQ, M1_VALID, M2_VALID, M1_TX_ADDR, M2_TX_ADDR;
  logic [1:0] bus_grant, slave_select;
  logic       M1_GRANT, M2_GRANT, M1_ACK, M2_ACK, M1_ERR, M2_ERR;

  int unsigned total = 0;
  int unsigned bad   = 0;

  bus_arbiter_decoder #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .M1_REQ(M1_REQ), .M2_REQ(M2_REQ),
    .M1_VALID(M1_VALID), .M2_VALID(M2_VALID),
    .M1_TX_ADDR(M1_TX_ADDR), .M2_TX_ADDR(M2_TX_ADDR),
    .bus_grant(bus_grant), .slave_select(slave_select),
    .M1_GRANT(M1_GRANT), .M2_GRANT(M2_GRANT),
    .M1_ACK(M1_ACK), .M2_ACK(M2_ACK),
    .M1_ERR(M1_ERR), .M2_ERR(M2_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string    name;
    bit [6:0] in;    // {rst, r1, v1, a1, r2, v2, a2}
    bit [9:0] exp;   // {grant[1:0], sel[1:0], g1, g2, ack1, ack2, err1, err2}
  } vec_t;

  vec_t vecs[$];

  // ak/er: bit0 = M1, bit1 = M2
  function automatic void add(string n, bit rst, bit r1, bit v1, bit a1,
                              bit r2, bit v2, bit a2,
                              bit [1:0] g, bit [1:0] s, bit [1:0] ak, bit [1:0] er);
    vec_t v;
    v.name = n;
    v.in   = {rst, r1, v1, a1, r2, v2, a2};
    v.exp  = {g, s, g == 2'd1, g == 2'd2, ak[0], ak[1], er[0], er[1]};
    vecs.push_back(v);
  endfunction

  function automatic bit [9:0] outs();
    return {bus_grant, slave_select, M1_GRANT, M2_GRANT, M1_ACK, M2_ACK, M1_ERR, M2_ERR};
  endfunction

  task automatic check(string n, bit [9:0] exp);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (grant,sel,g1,g2,ack1,ack2,err1,err2)",
               n, outs(), exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    {M1_REQ, M1_VALID, M1_TX_ADDR, M2_REQ, M2_VALID, M2_TX_ADDR} = '0;

    //   name          rst r1 v1 a1 r2 v2 a2   grant sel ack err
    add("reset",        1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("s_grant",      0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    add("s_bit1",       0, 1, 1, 1, 0, 0, 0,   1, 0, 0, 0);
    add("s_bit0_ack",   0, 1, 1, 0, 0, 0, 0,   1, 2, 1, 0);
    add("s_hold",       0, 1, 0, 1, 0, 1, 1,   1, 2, 0, 0);
    add("s_rel",        0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("s_idle",       0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("c_reset",      1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("c_m1_wins",    0, 1, 0, 0, 1, 0, 0,   1, 0, 0, 0);
    add("c_b0",         0, 1, 1, 0, 1, 1, 1,   1, 0, 0, 0);
    add("c_b1_ack",     0, 1, 1, 1, 1, 0, 0,   1, 1, 1, 0);
    add("c_m1_rel",     0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0);
    add("c_dead",       0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0);
    add("c_m2_grant",   0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 0);
    add("c_m2_b1",      0, 0, 1, 0, 1, 1, 1,   2, 0, 0, 0);
    add("c_m2_ack",     0, 0, 0, 0, 1, 1, 1,   2, 3, 2, 0);
    add("c_m2_rel",     0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("c_idle",       0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("c_m1_again",   0, 1, 0, 0, 1, 0, 0,   1, 0, 0, 0);
    add("a_bit",        0, 1, 1, 1, 1, 0, 0,   1, 0, 0, 0);
    add("a_abort",      0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0);
    add("a_dead",       0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0);
    add("i_m2_grant",   0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 0);
    add("i_b0",         0, 0, 0, 0, 1, 1, 0,   2, 0, 0, 0);
    add("i_err",        0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 2);
    add("i_rel",        0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("i_idle",       0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("g_grant",      0, 1, 0, 0, 0, 1, 0,   1, 0, 0, 0);
    add("g_b1",         0, 1, 1, 1, 0, 1, 0,   1, 0, 0, 0);
    add("g_gap1",       0, 1, 0, 0, 0, 1, 1,   1, 0, 0, 0);
    add("g_gap2",       0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    add("g_gap3",       0, 1, 0, 1, 0, 1, 0,   1, 0, 0, 0);
    add("g_b1_ack",     0, 1, 1, 1, 0, 0, 0,   1, 3, 1, 0);
    add("g_rel",        0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("g_idle",       0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("t_grant",      0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    add("t_b0",         0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0);
    add("t_b1_ack",     0, 1, 1, 1, 0, 0, 0,   1, 1, 1, 0);
    for (int i = 0; i < 5; i++)
      add("t_hold",     0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    add("t_timeout",    0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add("t_dead",       0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("t_locked1",    0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("t_locked2",    0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("t_req_low",    0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("t_regrant",    0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    add("t_rel",        0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("t_idle",       0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add("r_m2_grant",   0, 0, 0, 0, 1, 0, 0,   2, 0, 0, 0);
    add("r_b0",         0, 0, 0, 0, 1, 1, 0,   2, 0, 0, 0);
    add("r_b1_ack",     0, 0, 0, 0, 1, 1, 1,   2, 1, 2, 0);
    add("r_hold",       0, 0, 0, 0, 1, 0, 0,   2, 1, 0, 0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      {RST, M1_REQ, M1_VALID, M1_TX_ADDR, M2_REQ, M2_VALID, M2_TX_ADDR} = vecs[i].in;
      @(posedge CLK);
      #1 check(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset in the middle of a CONNECT owned by M2.
    #2 RST = 1'b1;
    #1 check("async_rst", 10'b0);
    @(negedge CLK);
    RST = 1'b0;
    M1_REQ = 1'b1;
    M2_REQ = 1'b1;
    @(posedge CLK);
    #1 check("post_rst_m1_wins", {2'd1, 2'd0, 1'b1, 1'b0, 4'b0});
    @(negedge CLK);
    {M1_VALID, M1_TX_ADDR} = 2'b11;
    @(posedge CLK);
    #1 check("post_rst_bit1", {2'd1, 2'd0, 1'b1, 1'b0, 4'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
